// File: rtl/jtlb_ctl_pkg.sv
// Shared types for the JTLB sequencer: CP0 op codes, response exception codes, FSM states.
package jtlb_ctl_pkg;

  typedef enum logic [1:0] {
    OpTlbr  = 2'd0,
    OpTlbwi = 2'd1,
    OpTlbwr = 2'd2,
    OpTlbp  = 2'd3
  } tlb_op_e;

  typedef enum logic [2:0] {
    ExcNone  = 3'd0,
    ExcAde   = 3'd1,
    ExcMiss  = 3'd2,
    ExcInval = 3'd3,
    ExcMod   = 3'd4
  } rsp_exc_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLook = 2'd1,
    StResp = 2'd2,
    StOp   = 2'd3
  } jtlb_state_e;

  localparam logic RspIdI = 1'b0;
  localparam logic RspIdD = 1'b1;

  // A multiple-hit shutdown is reported to the requester as a miss.
  function automatic rsp_exc_e exc_encode(input logic shut, input logic ade, input logic miss,
                                          input logic inval, input logic mod);
    rsp_exc_e e;
    if (shut)       e = ExcMiss;
    else if (ade)   e = ExcAde;
    else if (miss)  e = ExcMiss;
    else if (inval) e = ExcInval;
    else if (mod)   e = ExcMod;
    else            e = ExcNone;
    return e;
  endfunction

endpackage

// File: rtl/jtlb_ctl_if.sv
// Requester, CP0 and JTLB-facing signals of the JTLB sequencer.
interface jtlb_ctl_if #(
  parameter int unsigned VA_W = 64,
  parameter int unsigned PA_W = 32
);

  logic            ireq;
  logic [VA_W-1:0] iva;
  logic            igrant;
  logic            dreq;
  logic [VA_W-1:0] dva;
  logic            dwr;
  logic            dgrant;
  logic            opreq;
  logic [1:0]      op;
  logic            opdone;

  logic [VA_W-1:0] jtlbva;
  logic            jtlbreq;
  logic            jtlbwr;
  logic            tlbr;
  logic            tlbwi;
  logic            tlbwr;
  logic            tlbp;
  logic [PA_W-1:0] jtlbpa;
  logic            jtlbcache;
  logic            jtlbmiss;
  logic            jtlbade;
  logic            jtlbinval;
  logic            jtlbmod;
  logic            cp0jtlbshut;

  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [PA_W-1:0] rsp_pa;
  logic            rsp_cache;
  logic [2:0]      rsp_exc;
  logic            utlb_flush;
  logic            tlb_shutdown;

  // Environment side: micro-TLBs, CP0 and the JTLB array.
  modport master (
    output ireq, iva, dreq, dva, dwr, opreq, op, rsp_ready,
    output jtlbpa, jtlbcache, jtlbmiss, jtlbade, jtlbinval, jtlbmod, cp0jtlbshut,
    input  igrant, dgrant, opdone, jtlbva, jtlbreq, jtlbwr, tlbr, tlbwi, tlbwr, tlbp,
    input  rsp_valid, rsp_id, rsp_pa, rsp_cache, rsp_exc, utlb_flush, tlb_shutdown
  );

  // Sequencer side.
  modport slave (
    input  ireq, iva, dreq, dva, dwr, opreq, op, rsp_ready,
    input  jtlbpa, jtlbcache, jtlbmiss, jtlbade, jtlbinval, jtlbmod, cp0jtlbshut,
    output igrant, dgrant, opdone, jtlbva, jtlbreq, jtlbwr, tlbr, tlbwi, tlbwr, tlbp,
    output rsp_valid, rsp_id, rsp_pa, rsp_cache, rsp_exc, utlb_flush, tlb_shutdown
  );

endinterface

// File: rtl/jtlb_rr2.sv
// Two-way round-robin arbiter between the I and D micro-TLB refill requests.
module jtlb_rr2 (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic ireq,
  input  logic dreq,
  output logic igrant,
  output logic dgrant
);

  // rr_q = 0 favours D, 1 favours I.
  logic rr_q, rr_d;

  always_comb begin
    dgrant = en & dreq & (~ireq | ~rr_q);
    igrant = en & ireq & (~dreq | rr_q);
  end

  always_comb begin
    rr_d = rr_q;
    if (dgrant)      rr_d = 1'b1;
    else if (igrant) rr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/jtlb_ctl.sv
// JTLB sequencer: arbitrates micro-TLB refills and CP0 TLB ops onto the shared JTLB and
// returns registered lookup results on a single response bus.
module jtlb_ctl
  import jtlb_ctl_pkg::*;
#(
  parameter int unsigned VA_W = 64,
  parameter int unsigned PA_W = 32
) (
  input logic         clk,
  input logic         rstn,
  input logic         phi2,
  jtlb_ctl_if.slave   bus
);

  jtlb_state_e     state_q, state_d;
  logic [VA_W-1:0] va_q;
  logic            wr_q;
  logic            id_q;
  tlb_op_e         op_q;
  logic [PA_W-1:0] pa_q;
  logic            cache_q;
  rsp_exc_e        exc_q;
  logic            shut_q;

  logic arb_en, op_go, arb_igrant, arb_dgrant;

  // Grants are masked during reset so every output reads zero while rstn is low.
  assign op_go  = rstn & (state_q == StIdle) & bus.opreq;
  assign arb_en = rstn & (state_q == StIdle) & ~bus.opreq;

  jtlb_rr2 u_rr2 (
    .clk    (clk),
    .rstn   (rstn),
    .en     (arb_en),
    .ireq   (bus.ireq),
    .dreq   (bus.dreq),
    .igrant (arb_igrant),
    .dgrant (arb_dgrant)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (op_go)                          state_d = StOp;
        else if (arb_igrant || arb_dgrant)  state_d = StLook;
      end
      StLook: state_d = StResp;
      StResp: if (bus.rsp_ready) state_d = StIdle;
      StOp:   if (phi2)          state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic igrant, dgrant, opdone, jtlbreq, jtlbwr, tlbr, tlbwi, tlbwr, tlbp, rsp_valid, utlb_flush;

  always_comb begin
    igrant     = 1'b0;
    dgrant     = 1'b0;
    opdone     = 1'b0;
    jtlbreq    = 1'b0;
    jtlbwr     = 1'b0;
    tlbr       = 1'b0;
    tlbwi      = 1'b0;
    tlbwr      = 1'b0;
    tlbp       = 1'b0;
    rsp_valid  = 1'b0;
    utlb_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        igrant = arb_igrant & ~op_go;
        dgrant = arb_dgrant & ~op_go;
      end
      StLook: begin
        jtlbreq = 1'b1;
        jtlbwr  = wr_q & (id_q == RspIdD);
      end
      StResp: rsp_valid = 1'b1;
      StOp: begin
        tlbr       = (op_q == OpTlbr);
        tlbwi      = (op_q == OpTlbwi);
        tlbwr      = (op_q == OpTlbwr);
        tlbp       = (op_q == OpTlbp);
        opdone     = phi2;
        // Any JTLB write may alias stale micro-TLB entries.
        utlb_flush = phi2 & ((op_q == OpTlbwi) || (op_q == OpTlbwr));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      va_q    <= '0;
      wr_q    <= 1'b0;
      id_q    <= RspIdI;
      op_q    <= OpTlbr;
      pa_q    <= '0;
      cache_q <= 1'b0;
      exc_q   <= ExcNone;
      shut_q  <= 1'b0;
    end else begin
      if (dgrant) begin
        va_q <= bus.dva;
        wr_q <= bus.dwr;
        id_q <= RspIdD;
      end else if (igrant) begin
        va_q <= bus.iva;
        wr_q <= 1'b0;
        id_q <= RspIdI;
      end
      if (op_go) op_q <= tlb_op_e'(bus.op);
      if (state_q == StLook) begin
        pa_q    <= bus.jtlbpa;
        cache_q <= bus.jtlbcache;
        exc_q   <= exc_encode(bus.cp0jtlbshut, bus.jtlbade, bus.jtlbmiss, bus.jtlbinval,
                              bus.jtlbmod);
        if (bus.cp0jtlbshut) shut_q <= 1'b1;
      end
    end
  end

  assign bus.igrant       = igrant;
  assign bus.dgrant       = dgrant;
  assign bus.opdone       = opdone;
  assign bus.jtlbva       = va_q;
  assign bus.jtlbreq      = jtlbreq;
  assign bus.jtlbwr       = jtlbwr;
  assign bus.tlbr         = tlbr;
  assign bus.tlbwi        = tlbwi;
  assign bus.tlbwr        = tlbwr;
  assign bus.tlbp         = tlbp;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_pa       = pa_q;
  assign bus.rsp_cache    = cache_q;
  assign bus.rsp_exc      = exc_q;
  assign bus.utlb_flush   = utlb_flush;
  assign bus.tlb_shutdown = shut_q;

endmodule

// File: tb/tb_jtlb_ctl.sv
// Directed bench for jtlb_ctl: arbitration order, lookup latency, CP0 op timing, shutdown, reset.
module tb_jtlb_ctl;

  logic clk = 1'b0;
  logic rstn;
  logic phi2;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   strobe_viol = 0;

  jtlb_ctl_if #(.VA_W(64), .PA_W(32)) bus ();

  jtlb_ctl #(.VA_W(64), .PA_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .phi2 (phi2),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if ($countones({bus.jtlbreq, bus.tlbr, bus.tlbwi, bus.tlbwr, bus.tlbp}) > 1) strobe_viol++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {bus.igrant, bus.dgrant, bus.opdone, bus.jtlbreq, bus.jtlbwr, bus.tlbr, bus.tlbwi,
            bus.tlbwr, bus.tlbp, bus.rsp_valid, bus.rsp_id, bus.rsp_cache, bus.rsp_exc,
            bus.utlb_flush, bus.tlb_shutdown};
  endfunction

  function automatic logic [3:0] strobes();
    return {bus.tlbr, bus.tlbwi, bus.tlbwr, bus.tlbp};
  endfunction

  // Called in an IDLE cycle right after a negedge; expects the grant in this cycle.
  // fl = {shut, ade, miss, inval, mod}
  task automatic lookup(input string tag, input bit side_d, input logic [63:0] va, input bit wr,
                        input logic [31:0] pa, input bit cache, input logic [4:0] fl,
                        input logic [2:0] exp_exc);
    if (side_d) begin
      bus.dreq = 1'b1; bus.dva = va; bus.dwr = wr;
    end else begin
      bus.ireq = 1'b1; bus.iva = va;
    end
    #1;
    check({tag, "_gnt"}, {bus.igrant, bus.dgrant}, side_d ? 2'b01 : 2'b10);
    @(negedge clk);
    if (side_d) bus.dreq = 1'b0; else bus.ireq = 1'b0;
    bus.jtlbpa = pa;
    bus.jtlbcache = cache;
    {bus.cp0jtlbshut, bus.jtlbade, bus.jtlbmiss, bus.jtlbinval, bus.jtlbmod} = fl;
    #1;
    check({tag, "_look"}, {bus.jtlbreq, bus.jtlbwr, strobes()}, {1'b1, side_d & wr, 4'b0000});
    check({tag, "_va"}, bus.jtlbva, va);
    @(negedge clk);
    bus.jtlbpa = 32'hffff_ffff;
    bus.jtlbcache = 1'b0;
    {bus.cp0jtlbshut, bus.jtlbade, bus.jtlbmiss, bus.jtlbinval, bus.jtlbmod} = 5'b0;
    #1;
    check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_cache, bus.rsp_exc},
          {1'b1, side_d, cache, exp_exc});
    check({tag, "_pa"}, bus.rsp_pa, pa);
    check({tag, "_nogrant"}, {bus.igrant, bus.dgrant, bus.jtlbreq}, 3'b000);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // wait_cycles = OP cycles with phi2 low before the committing cycle.
  task automatic cp0_op(input string tag, input logic [1:0] op, input int wait_cycles,
                        input logic [3:0] exp_strobe, input bit exp_flush);
    bus.opreq = 1'b1;
    bus.op = op;
    phi2 = 1'b0;
    #1;
    check({tag, "_idle"}, {bus.igrant, bus.dgrant, strobes()}, 6'b0);
    @(negedge clk);
    for (int i = 0; i < wait_cycles; i++) begin
      #1;
      check({tag, "_hold"}, {strobes(), bus.opdone, bus.utlb_flush}, {exp_strobe, 2'b00});
      @(negedge clk);
    end
    phi2 = 1'b1;
    #1;
    check({tag, "_done"}, {strobes(), bus.opdone, bus.utlb_flush}, {exp_strobe, 1'b1, exp_flush});
    bus.opreq = 1'b0;
    @(negedge clk);
    phi2 = 1'b0;
    #1;
    check({tag, "_after"}, {strobes(), bus.opdone, bus.utlb_flush}, 6'b0);
  endtask

  initial begin
    rstn = 1'b0;
    phi2 = 1'b0;
    bus.ireq = 1'b0; bus.iva = '0; bus.dreq = 1'b0; bus.dva = '0; bus.dwr = 1'b0;
    bus.opreq = 1'b0; bus.op = 2'd0; bus.rsp_ready = 1'b0;
    bus.jtlbpa = '0; bus.jtlbcache = 1'b0; bus.jtlbmiss = 1'b0; bus.jtlbade = 1'b0;
    bus.jtlbinval = 1'b0; bus.jtlbmod = 1'b0; bus.cp0jtlbshut = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", outs(), 17'b0);
    check("reset_va", bus.jtlbva, 64'h0);
    check("reset_pa", bus.rsp_pa, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Simultaneous I and D after reset: D first, then I.
    bus.ireq = 1'b1; bus.iva = 64'h2000;
    lookup("both_d", 1'b1, 64'h3000, 1'b0, 32'h0003_3000, 1'b1, 5'b00000, 3'd0);
    lookup("both_i", 1'b0, 64'h2000, 1'b0, 32'h0002_2000, 1'b0, 5'b00000, 3'd0);

    lookup("store_mod", 1'b1, 64'h1000, 1'b1, 32'h0020_1000, 1'b0, 5'b00001, 3'd4);
    lookup("exc_ade", 1'b0, 64'hffff_ffff_8000_0000, 1'b0, 32'h0000_0010, 1'b0, 5'b01101, 3'd1);
    lookup("exc_miss", 1'b1, 64'h4444, 1'b1, 32'h0000_4444, 1'b1, 5'b00110, 3'd2);
    lookup("exc_inval", 1'b0, 64'h5555, 1'b0, 32'h0000_5555, 1'b0, 5'b00011, 3'd3);
    lookup("exc_none", 1'b1, 64'h6666, 1'b0, 32'h1234_5678, 1'b1, 5'b00000, 3'd0);

    cp0_op("tlbwi", 2'd1, 2, 4'b0100, 1'b1);
    cp0_op("tlbr", 2'd0, 0, 4'b1000, 1'b0);

    // Response back-pressure with D waiting; rr favours I after the last D grant.
    bus.ireq = 1'b1; bus.iva = 64'h4000;
    bus.dreq = 1'b1; bus.dva = 64'h5000; bus.dwr = 1'b0;
    #1;
    check("bp_gnt", {bus.igrant, bus.dgrant}, 2'b10);
    @(negedge clk);
    bus.ireq = 1'b0;
    bus.jtlbpa = 32'h0040_4000; bus.jtlbcache = 1'b1;
    @(negedge clk);
    bus.jtlbpa = 32'h0;
    bus.jtlbcache = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_cache, bus.rsp_exc, bus.dgrant},
            {1'b1, 1'b0, 1'b1, 3'd0, 1'b0});
      check("bp_pa", bus.rsp_pa, 32'h0040_4000);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release", bus.dgrant, 1'b0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    lookup("bp_d", 1'b1, 64'h5000, 1'b0, 32'h0050_5000, 1'b0, 5'b00000, 3'd0);

    lookup("shut", 1'b1, 64'h7000, 1'b0, 32'h0070_7000, 1'b0, 5'b10000, 3'd2);
    #1;
    check("shut_flag", bus.tlb_shutdown, 1'b1);
    lookup("shut_sticky", 1'b0, 64'h8000, 1'b0, 32'h0080_8000, 1'b0, 5'b00000, 3'd0);
    #1;
    check("shut_still", bus.tlb_shutdown, 1'b1);

    // Reset in the middle of a lookup.
    bus.dreq = 1'b1; bus.dva = 64'h9000; bus.dwr = 1'b1;
    @(negedge clk);
    bus.dreq = 1'b0;
    #1;
    check("rst_look_pre", {bus.jtlbreq, bus.jtlbwr}, 2'b11);
    rstn = 1'b0;
    #1;
    check("rst_look_outs", outs(), 17'b0);
    check("rst_look_va", bus.jtlbva, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("rst_look_after", outs(), 17'b0);

    // Reset in the middle of a TLBWR.
    bus.opreq = 1'b1; bus.op = 2'd2; phi2 = 1'b0;
    @(negedge clk);
    #1;
    check("rst_op_pre", strobes(), 4'b0010);
    rstn = 1'b0;
    bus.opreq = 1'b0;
    #1;
    check("rst_op_outs", outs(), 17'b0);
    @(negedge clk);
    phi2 = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("rst_op_after", outs(), 17'b0);
    phi2 = 1'b0;
    @(negedge clk);

    // op, D and I together: op first, then D, then I.
    bus.dreq = 1'b1; bus.dva = 64'ha000; bus.dwr = 1'b0;
    bus.ireq = 1'b1; bus.iva = 64'hb000;
    cp0_op("all_op", 2'd3, 0, 4'b0001, 1'b0);
    lookup("all_d", 1'b1, 64'ha000, 1'b0, 32'h00a0_a000, 1'b0, 5'b00000, 3'd0);
    lookup("all_i", 1'b0, 64'hb000, 1'b0, 32'h00b0_b000, 1'b1, 5'b00000, 3'd0);

    check("strobe_onehot", strobe_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
